// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants and state encoding for the terminal console writer
package term_pkg;

  localparam int TERM_COLS = 80;
  localparam int TERM_ROWS = 30;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SPACE) && (b <= CH_TILDE);
  endfunction

endpackage

// File: rtl/terminal_console.sv
// rtl/terminal_console.sv - byte stream to text-RAM writer with cursor, wrap, LF/CR/BS and screen clear
module terminal_console
  import term_pkg::*;
#(
  parameter int COLS   = TERM_COLS,
  parameter int ROWS   = TERM_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] term_addr,
  output logic              term_write,
  output logic [7:0]        term_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W:0]   LINE_N   = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W:0]   SCREEN_N = (ADDR_W+1)'(ROWS * COLS);
  localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [6:0]          r_col;
  logic [4:0]          r_row;
  logic [ADDR_W-1:0]   r_row_base;
  logic [ADDR_W:0]     r_idx;
  logic                r_wrap;
  logic                r_term_write;
  logic [ADDR_W-1:0]   r_term_addr;
  logic [7:0]          r_term_data;

  logic                w_last_row;
  logic [4:0]          w_next_row;
  logic [ADDR_W-1:0]   w_next_base;
  logic [ADDR_W-1:0]   w_cur_addr;

  // row_base advances by COLS per row so the address never needs a multiply
  assign w_last_row  = (r_row == LAST_ROW);
  assign w_next_row  = w_last_row ? 5'd0 : r_row + 5'd1;
  assign w_next_base = w_last_row ? '0 : r_row_base + COLS_A;
  assign w_cur_addr  = r_row_base + ADDR_W'(r_col);

  assign char_ready = (r_state == ST_IDLE) && !clear_req;
  assign busy       = (r_state != ST_IDLE);
  assign term_write = r_term_write;
  assign term_addr  = r_term_addr;
  assign term_data  = r_term_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_row_base   <= '0;
      r_idx        <= '0;
      r_wrap       <= 1'b0;
      r_term_write <= 1'b0;
      r_term_addr  <= '0;
      r_term_data  <= '0;
    end else begin
      r_term_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state      <= ST_CLR_ALL;
            r_term_write <= 1'b1;
            r_term_addr  <= '0;
            r_term_data  <= CH_SPACE;
            r_idx        <= IDX_ONE;
          end else if (char_valid) begin
            r_state <= ST_WRITE;
            r_wrap  <= 1'b0;
            if (is_printable(char_data)) begin
              r_term_write <= 1'b1;
              r_term_addr  <= w_cur_addr;
              r_term_data  <= char_data;
              if (r_col == LAST_COL) begin
                r_col      <= '0;
                r_row      <= w_next_row;
                r_row_base <= w_next_base;
                r_wrap     <= 1'b1;
              end else begin
                r_col <= r_col + 7'd1;
              end
            end else if (char_data == CH_LF) begin
              // the first blank of the new row is issued right away
              r_state      <= ST_CLR_LINE;
              r_col        <= '0;
              r_row        <= w_next_row;
              r_row_base   <= w_next_base;
              r_term_write <= 1'b1;
              r_term_addr  <= w_next_base;
              r_term_data  <= CH_SPACE;
              r_idx        <= IDX_ONE;
            end else if (char_data == CH_CR) begin
              r_col <= '0;
            end else if (char_data == CH_BS && r_col != 7'd0) begin
              r_col        <= r_col - 7'd1;
              r_term_write <= 1'b1;
              r_term_addr  <= w_cur_addr - ADDR_W'(1);
              r_term_data  <= CH_SPACE;
            end
          end
        end
        ST_WRITE: begin
          if (r_wrap) begin
            r_state      <= ST_CLR_LINE;
            r_wrap       <= 1'b0;
            r_term_write <= 1'b1;
            r_term_addr  <= r_row_base;
            r_term_data  <= CH_SPACE;
            r_idx        <= IDX_ONE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLR_LINE: begin
          if (r_idx == LINE_N) begin
            r_state <= ST_IDLE;
          end else begin
            r_term_write <= 1'b1;
            r_term_addr  <= r_row_base + r_idx[ADDR_W-1:0];
            r_term_data  <= CH_SPACE;
            r_idx        <= r_idx + IDX_ONE;
          end
        end
        ST_CLR_ALL: begin
          if (r_idx == SCREEN_N) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
          end else begin
            r_term_write <= 1'b1;
            r_term_addr  <= r_idx[ADDR_W-1:0];
            r_term_data  <= CH_SPACE;
            r_idx        <= r_idx + IDX_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_terminal_console.sv
// tb/tb_terminal_console.sv - directed self-checking bench for terminal_console
module tb_terminal_console;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        clear_req;
  logic [11:0] term_addr;
  logic        term_write;
  logic [7:0]  term_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int ready_in_busy;

  terminal_console #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear_req(clear_req), .term_addr(term_addr),
    .term_write(term_write), .term_data(term_data), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int budget);
    int cyc = 0;
    wr_addr.delete();
    wr_data.delete();
    ready_in_busy = 0;
    while (busy && cyc < budget) begin
      if (term_write) begin
        wr_addr.push_back(term_addr);
        wr_data.push_back(term_data);
      end
      if (char_ready) ready_in_busy++;
      tick();
      cyc++;
    end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL collect_timeout: busy=%0b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    char_valid = 1'b1;
    char_data  = b;
    while (!char_ready && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (!char_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: char_ready=%0b for byte %h, required 1", char_ready, b);
    end
    tick();
    char_valid = 1'b0;
  endtask

  task automatic send_quiet(input logic [7:0] b);
    send_byte(b);
    collect(3000);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00; clear_req = 1'b0;
    #12;
    n_tests++;
    if ({term_write, term_addr, term_data} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got w=%b a=%h d=%h, required 0 0 0", term_write, term_addr, term_data);
    end
    n_tests++;
    if ({cursor_col, cursor_row, busy, char_ready} !== {7'd0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got col=%0d row=%0d busy=%b rdy=%b, required 0 0 0 1",
               cursor_col, cursor_row, busy, char_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_char;
    send_byte(8'h41);
    n_tests++;
    if ({term_write, term_addr, term_data} !== {1'b1, 12'd0, 8'h41}) begin
      n_fail++;
      $display("FAIL char_write: got w=%b a=%0d d=%h, required 1 0 41", term_write, term_addr, term_data);
    end
    n_tests++;
    if ({cursor_col, cursor_row, char_ready} !== {7'd1, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL char_cursor: got col=%0d row=%0d rdy=%b, required 1 0 0", cursor_col, cursor_row, char_ready);
    end
    tick();
    n_tests++;
    if ({char_ready, term_write, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL char_after: got rdy=%b w=%b busy=%b, required 1 0 0", char_ready, term_write, busy);
    end
  endtask

  task automatic test_cr;
    send_byte(8'h0D);
    collect(10);
    n_tests++;
    if (wr_addr.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL cr: got writes=%0d col=%0d row=%0d, required 0 0 0", wr_addr.size(), cursor_col, cursor_row);
    end
  endtask

  task automatic test_wrap;
    int bad = 0;
    int cbad = 0;
    for (int i = 0; i < 80; i++) begin
      send_byte(8'h78);
      collect(200);
      if (i < 79 && (wr_addr.size() != 1 || wr_addr[0] != 12'(i) || wr_data[0] != 8'h78)) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_chars: got %0d bad character writes, required 0", bad);
    end
    n_tests++;
    if (wr_addr.size() != 81) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes after last char, required 81", wr_addr.size());
    end else begin
      if (wr_addr[0] != 12'd79 || wr_data[0] != 8'h78) cbad++;
      for (int k = 1; k <= 80; k++)
        if (wr_addr[k] != 12'(79 + k) || wr_data[k] != 8'h20) cbad++;
      n_tests++;
      if (cbad != 0) begin
        n_fail++;
        $display("FAIL wrap_clear: got %0d bad writes in 79..159, required 0", cbad);
      end
    end
    n_tests++;
    if (ready_in_busy != 0 || cursor_col !== 7'd0 || cursor_row !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_cursor: got rdy_busy=%0d col=%0d row=%0d, required 0 0 1",
               ready_in_busy, cursor_col, cursor_row);
    end
  endtask

  task automatic test_bs;
    send_quiet(8'h0A);
    for (int i = 0; i < 5; i++) send_quiet(8'h61);
    send_byte(8'h08);
    collect(20);
    n_tests++;
    if (wr_addr.size() != 1 || wr_addr[0] != 12'd164 || wr_data[0] != 8'h20) begin
      n_fail++;
      $display("FAIL bs_write: got writes=%0d a=%0d, required 1 write at 164 of 20",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 12'd0);
    end
    n_tests++;
    if (cursor_col !== 7'd4 || cursor_row !== 5'd2) begin
      n_fail++;
      $display("FAIL bs_cursor: got col=%0d row=%0d, required 4 2", cursor_col, cursor_row);
    end
    send_quiet(8'h0D);
    send_byte(8'h08);
    collect(20);
    n_tests++;
    if (wr_addr.size() != 0 || cursor_col !== 7'd0 || cursor_row !== 5'd2 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bs_col0: got writes=%0d col=%0d row=%0d rdy=%b, required 0 0 2 1",
               wr_addr.size(), cursor_col, cursor_row, char_ready);
    end
  endtask

  task automatic test_lf_wrap;
    int cbad = 0;
    for (int i = 0; i < 27; i++) send_quiet(8'h0A);
    for (int i = 0; i < 12; i++) send_quiet(8'h63);
    n_tests++;
    if (cursor_col !== 7'd12 || cursor_row !== 5'd29) begin
      n_fail++;
      $display("FAIL lf_setup: got col=%0d row=%0d, required 12 29", cursor_col, cursor_row);
    end
    send_byte(8'h0A);
    collect(200);
    n_tests++;
    if (wr_addr.size() != 80) begin
      n_fail++;
      $display("FAIL lf_count: got %0d writes, required 80", wr_addr.size());
    end else begin
      for (int k = 0; k < 80; k++)
        if (wr_addr[k] != 12'(k) || wr_data[k] != 8'h20) cbad++;
      n_tests++;
      if (cbad != 0) begin
        n_fail++;
        $display("FAIL lf_clear: got %0d bad writes in 0..79, required 0", cbad);
      end
    end
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL lf_cursor: got col=%0d row=%0d, required 0 0", cursor_col, cursor_row);
    end
  endtask

  task automatic test_clear_priority;
    int cbad = 0;
    send_quiet(8'h71);
    char_valid = 1'b1;
    char_data  = 8'h42;
    clear_req  = 1'b1;
    tick();
    clear_req = 1'b0;
    n_tests++;
    if ({busy, term_write, term_addr, term_data} !== {1'b1, 1'b1, 12'd0, 8'h20}) begin
      n_fail++;
      $display("FAIL clr_start: got busy=%b w=%b a=%0d d=%h, required 1 1 0 20", busy, term_write, term_addr, term_data);
    end
    collect(2600);
    n_tests++;
    if (wr_addr.size() != 2400) begin
      n_fail++;
      $display("FAIL clr_count: got %0d writes, required 2400", wr_addr.size());
    end else begin
      for (int k = 0; k < 2400; k++)
        if (wr_addr[k] != 12'(k) || wr_data[k] != 8'h20) cbad++;
      n_tests++;
      if (cbad != 0) begin
        n_fail++;
        $display("FAIL clr_content: got %0d bad writes in 0..2399, required 0", cbad);
      end
    end
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || char_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_end: got col=%0d row=%0d rdy=%b, required 0 0 1", cursor_col, cursor_row, char_ready);
    end
    tick();
    char_valid = 1'b0;
    n_tests++;
    if ({term_write, term_addr, term_data, cursor_col} !== {1'b1, 12'd0, 8'h42, 7'd1}) begin
      n_fail++;
      $display("FAIL clr_pending: got w=%b a=%0d d=%h col=%0d, required 1 0 42 1",
               term_write, term_addr, term_data, cursor_col);
    end
    collect(10);
  endtask

  task automatic test_reset_mid_clear;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    n_tests++;
    if (busy !== 1'b1 || term_write !== 1'b1 || cursor_col !== 7'd1) begin
      n_fail++;
      $display("FAIL mid_clear: got busy=%b w=%b col=%0d, required 1 1 1", busy, term_write, cursor_col);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (term_write !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got w=%b col=%0d row=%0d busy=%b, required 0 0 0 0",
               term_write, cursor_col, cursor_row, busy);
    end
    #1;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (char_ready !== 1'b1 || busy !== 1'b0 || term_write !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b busy=%b w=%b, required 1 0 0", char_ready, busy, term_write);
    end
    send_byte(8'h5A);
    n_tests++;
    if ({term_write, term_addr, term_data} !== {1'b1, 12'd0, 8'h5A}) begin
      n_fail++;
      $display("FAIL post_reset_char: got w=%b a=%0d d=%h, required 1 0 5a", term_write, term_addr, term_data);
    end
    collect(10);
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_cr();
    test_wrap();
    test_bs();
    test_lf_wrap();
    test_clear_priority();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
